// File: rtl/spectrum_peak_buffer.sv
// Double-buffered spectrum display store: captures one frame of magnitude bins into the
// back bank (live, peak-hold or peak-decay), then swaps it to the front bank for reading.
module spectrum_peak_buffer #(
  parameter int unsigned N_BINS     = 512,
  parameter int unsigned MAG_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 9,
  parameter int unsigned SHIFT      = 2,
  parameter int unsigned DECAY_DIV  = 16,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        mag_valid,
  input  logic [MAG_WIDTH-1:0]        mag_data,
  input  logic [1:0]                  mode,
  input  logic [$clog2(N_BINS)-1:0]   rd_addr,
  output logic [OUT_WIDTH-1:0]        rd_data,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overrun
);

  localparam int unsigned AW   = $clog2(N_BINS);
  localparam int unsigned FC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [AW-1:0]        LAST_BIN = AW'(N_BINS - 1);
  localparam logic [FC_W-1:0]      FC_LAST  = FC_W'(DECAY_DIV - 1);
  localparam logic [OUT_WIDTH-1:0] STEP     = OUT_WIDTH'(DECAY_STEP);

  localparam logic [1:0] MODE_HOLD  = 2'b01;
  localparam logic [1:0] MODE_DECAY = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic [1:0]             mode_q, mode_d;
  logic                   sel_q, sel_d;
  logic [FC_W-1:0]        fcnt_q, fcnt_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q;
  logic [OUT_WIDTH-1:0]   rd_data_q;

  // bank_q[sel_q] is the front (displayed) bank, the other one is being filled
  logic [1:0][N_BINS-1:0][OUT_WIDTH-1:0] bank_q;

  logic                   we_c;
  logic                   decay_tick_c;
  logic [MAG_WIDTH-1:0]   shifted_c;
  logic [OUT_WIDTH-1:0]   scaled_c;
  logic [OUT_WIDTH-1:0]   front_c;
  logic [OUT_WIDTH-1:0]   decayed_c;
  logic [OUT_WIDTH-1:0]   floor_c;
  logic [OUT_WIDTH-1:0]   wdata_c;

  assign decay_tick_c = (fcnt_q == FC_LAST);

  // Scale and saturate the incoming magnitude
  assign shifted_c = mag_data >> SHIFT;
  assign scaled_c  = (|shifted_c[MAG_WIDTH-1:OUT_WIDTH]) ? '1 : shifted_c[OUT_WIDTH-1:0];

  // Write value: live uses a zero floor, so max() reduces to the scaled sample
  always_comb begin
    front_c   = bank_q[sel_q][cnt_q];
    decayed_c = (front_c > STEP) ? (front_c - STEP) : '0;
    floor_c   = '0;
    case (mode_q)
      MODE_HOLD:  floor_c = front_c;
      MODE_DECAY: floor_c = decay_tick_c ? decayed_c : front_c;
      default:    floor_c = '0;
    endcase
    wdata_c = (scaled_c > floor_c) ? scaled_c : floor_c;
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    sel_d        = sel_q;
    fcnt_d       = fcnt_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    we_c         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          mode_d  = mode;
        end
      end
      LOAD: begin
        if (start) begin
          overrun_d = 1'b1;
        end
        if (mag_valid) begin
          we_c = 1'b1;
          if (cnt_q == LAST_BIN) begin
            state_d      = IDLE;
            cnt_d        = '0;
            sel_d        = ~sel_q;
            frame_done_d = 1'b1;
            fcnt_d       = decay_tick_c ? '0 : (fcnt_q + FC_W'(1));
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mode_q       <= '0;
      sel_q        <= 1'b0;
      fcnt_q       <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      fcnt_q       <= fcnt_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d == LOAD);
    end
  end

  // Bank storage and registered front-bank read (sel_q is pre-swap on the swap edge)
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bank_q    <= '0;
      rd_data_q <= '0;
    end else begin
      if (we_c) begin
        bank_q[~sel_q][cnt_q] <= wdata_c;
      end
      rd_data_q <= bank_q[sel_q][rd_addr];
    end
  end

  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spectrum_peak_buffer.sv
// Directed bench for spectrum_peak_buffer: live, saturation, peak-hold, peak-decay,
// overrun, reset abort and swap-boundary read behaviour with hand-computed values.
module tb_spectrum_peak_buffer;

  localparam int unsigned N_BINS = 8;

  logic        CLOCK_50;
  logic        reset;
  logic        start;
  logic        mag_valid;
  logic [31:0] mag_data;
  logic [1:0]  mode;
  logic [2:0]  rd_addr;
  logic [8:0]  rd_data;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] frame_v [N_BINS];
  int          ovr_bin;
  bit          gap;
  logic        busy_seen;
  logic        fd_seen;

  spectrum_peak_buffer #(
    .N_BINS(8), .MAG_WIDTH(32), .OUT_WIDTH(9), .SHIFT(2), .DECAY_DIV(2), .DECAY_STEP(1)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .mag_valid (mag_valid),
    .mag_data  (mag_data),
    .mode      (mode),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_bin(input string tag, input int a, input logic [31:0] exp);
    rd_addr = 3'(a);
    tick();
    check($sformatf("%s_bin%0d", tag, a), 32'(rd_data), exp);
  endtask

  task automatic clear_frame();
    for (int k = 0; k < N_BINS; k++) frame_v[k] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    tick();
    start     = 1'b0;
    busy_seen = busy;
    for (int k = 0; k < N_BINS; k++) begin
      mag_valid = 1'b1;
      mag_data  = frame_v[k];
      start     = (k == ovr_bin);
      tick();
      mag_valid = 1'b0;
      start     = 1'b0;
      if (gap && k != N_BINS - 1) begin
        tick();
        tick();
      end
    end
    fd_seen = frame_done;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    mag_valid = 1'b0;
    mag_data  = '0;
    mode      = 2'b00;
    rd_addr   = '0;
    ovr_bin   = -1;
    gap       = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_rd_data", 32'(rd_data), 0);

    // mag_valid in IDLE is ignored
    mag_valid = 1'b1;
    mag_data  = 32'd400;
    tick();
    mag_valid = 1'b0;
    check("idle_valid_busy", 32'(busy), 0);

    // Live frame: 4*k -> k
    for (int k = 0; k < N_BINS; k++) frame_v[k] = 32'(4 * k);
    run_frame(2'b00);
    check("live_busy_in_load", 32'(busy_seen), 1);
    check("live_frame_done", 32'(fd_seen), 1);
    check("live_busy_after", 32'(busy), 0);
    tick();
    check("live_frame_done_pulse", 32'(frame_done), 0);
    for (int k = 0; k < N_BINS; k++) check_bin("live", k, 32'(k));

    // Saturation
    frame_v[3] = 32'h0000_1000;
    frame_v[4] = 32'd2044;
    frame_v[5] = 32'd2048;
    frame_v[6] = 32'hFFFF_FFFF;
    run_frame(2'b00);
    check_bin("sat", 2, 2);
    check_bin("sat", 3, 511);
    check_bin("sat", 4, 511);
    check_bin("sat", 5, 511);
    check_bin("sat", 6, 511);
    check_bin("sat", 7, 7);

    // Peak-hold, with idle gaps between samples
    gap = 1'b1;
    for (int k = 0; k < N_BINS; k++) frame_v[k] = 32'(4 * k);
    frame_v[2] = 32'd400;
    run_frame(2'b00);
    check_bin("hold_a", 2, 100);
    clear_frame();
    frame_v[2] = 32'd40;
    run_frame(2'b01);
    check("hold_b_frame_done", 32'(fd_seen), 1);
    check_bin("hold_b", 2, 100);
    check_bin("hold_b", 5, 5);
    frame_v[2] = 32'd800;
    run_frame(2'b01);
    check_bin("hold_c", 2, 200);
    clear_frame();
    frame_v[2] = 32'd40;
    run_frame(2'b11);
    check_bin("mode11_live", 2, 10);
    check_bin("mode11_live", 5, 0);
    gap = 1'b0;

    // Peak-decay: two live frames leave the completed-frame count even
    do_reset();
    clear_frame();
    frame_v[0] = 32'd20;
    run_frame(2'b00);
    run_frame(2'b00);
    check_bin("decay_setup", 0, 5);
    clear_frame();
    run_frame(2'b10);
    check_bin("decay_f1", 0, 5);
    run_frame(2'b10);
    check_bin("decay_f2", 0, 4);
    run_frame(2'b10);
    check_bin("decay_f3", 0, 4);
    run_frame(2'b10);
    check_bin("decay_f4", 0, 3);
    check_bin("decay_zero", 1, 0);

    // Overrun: start at bin 4, frame still completes
    for (int k = 0; k < N_BINS; k++) frame_v[k] = 32'(8 * k);
    ovr_bin = 4;
    run_frame(2'b00);
    ovr_bin = -1;
    check("ovr_set", 32'(overrun), 1);
    check("ovr_frame_done", 32'(fd_seen), 1);
    check("ovr_busy_after", 32'(busy), 0);
    check_bin("ovr", 7, 14);
    check("ovr_sticky", 32'(overrun), 1);

    // Reset at bin 5 aborts the frame; reset beats start and mag_valid
    start = 1'b1;
    mode  = 2'b00;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mag_valid = 1'b1;
      mag_data  = 32'd100;
      tick();
    end
    mag_valid = 1'b1;
    reset     = 1'b1;
    start     = 1'b1;
    tick();
    mag_valid = 1'b0;
    reset     = 1'b0;
    start     = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_overrun", 32'(overrun), 0);
    check("abort_frame_done", 32'(frame_done), 0);
    check("abort_rd_data", 32'(rd_data), 0);
    tick();
    check("abort_frame_done_late", 32'(frame_done), 0);
    for (int k = 0; k < N_BINS; k++) check_bin("abort", k, 0);
    for (int k = 0; k < 3; k++) begin
      mag_valid = 1'b1;
      mag_data  = 32'd400;
      tick();
    end
    mag_valid = 1'b0;
    check("abort_idle_busy", 32'(busy), 0);

    // Start together with the final mag_valid is ignored and sets overrun
    for (int k = 0; k < N_BINS; k++) frame_v[k] = 32'(4 * k);
    ovr_bin = N_BINS - 1;
    run_frame(2'b00);
    ovr_bin = -1;
    check("last_ovr_set", 32'(overrun), 1);
    check("last_ovr_frame_done", 32'(fd_seen), 1);
    check("last_ovr_busy", 32'(busy), 0);
    tick();
    check("last_ovr_busy_late", 32'(busy), 0);
    check_bin("last_ovr", 3, 3);

    // Swap boundary: read of bin 1 straddling the swap edge
    clear_frame();
    frame_v[1] = 32'd40;
    run_frame(2'b00);
    rd_addr = 3'd1;
    tick();
    check("swap_pre", 32'(rd_data), 10);
    frame_v[1] = 32'd80;
    run_frame(2'b00);
    check("swap_old", 32'(rd_data), 10);
    tick();
    check("swap_new", 32'(rd_data), 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spectrum_peak_buffer.md
SPECTRUM_PEAK_BUFFER -- requirements
Module: spectrum_peak_buffer

Interface
REQ-001 Parameter N_BINS, 512, number of magnitude bins per frame; SHALL be a power of two and at least 4.
REQ-002 Parameter MAG_WIDTH, 32, width of the incoming magnitude word.
REQ-003 Parameter OUT_WIDTH, 9, width of a stored and displayed bin value.
REQ-004 Parameter SHIFT, 2, right-shift applied to each magnitude before saturation.
REQ-005 Parameter DECAY_DIV, 16, number of completed frames per decay tick; minimum 1.
REQ-006 Parameter DECAY_STEP, 1, amount subtracted from a held peak on each decay tick.
REQ-007 Port CLOCK_50, input, 1, system clock; all logic SHALL be on its rising edge.
REQ-008 Port reset, input, 1, synchronous, active-high.
REQ-009 Port start, input, 1, single-cycle pulse requesting capture of one frame.
REQ-010 Port mag_valid, input, 1, qualifies mag_data for one cycle.
REQ-011 Port mag_data, input, MAG_WIDTH, unsigned magnitude of the current bin; bins arrive in ascending order.
REQ-012 Port mode, input, 2: 00 live, 01 peak-hold, 10 peak-decay, 11 treated as 00; sampled once per frame.
REQ-013 Port rd_addr, input, log2(N_BINS), display read address.
REQ-014 Port rd_data, output, OUT_WIDTH, front-bank value at rd_addr.
REQ-015 Port busy, output, 1, high while in LOAD.
REQ-016 Port frame_done, output, 1, one-cycle pulse when a completed frame becomes visible.
REQ-017 Port overrun, output, 1, sticky flag set when start is asserted while busy.

Function
REQ-018 The block SHALL hold two N_BINS x OUT_WIDTH banks (front and back); rd_data SHALL read the front bank only.
REQ-019 FSM states SHALL be IDLE and LOAD.
REQ-020 IDLE and start: go to LOAD, set bin counter to 0, and latch mode into mode_q.
REQ-021 In IDLE, mag_valid SHALL be ignored.
REQ-022 In LOAD, each mag_valid SHALL write back[cnt] = f(mag_data, front[cnt]) and then increment cnt.
REQ-023 The scaled value s SHALL be mag_data >> SHIFT, saturated to 2^OUT_WIDTH-1 when any bit above OUT_WIDTH-1 is set.
REQ-024 Write function f by mode_q:
- live: s.
- peak-hold: max(s, front[cnt]).
- peak-decay: max(s, d), where d = front[cnt] - DECAY_STEP floored at 0 on a decay-tick frame, else front[cnt].
REQ-025 A decay-tick frame SHALL be one where the completed-frame counter equals DECAY_DIV-1; that counter SHALL wrap to 0 at the end of the frame.
REQ-026 When mag_valid arrives with cnt == N_BINS-1: complete the write, swap front and back on the same edge, return to IDLE, pulse frame_done on the following cycle, and increment the completed-frame counter.
REQ-027 A start in LOAD SHALL be ignored and SHALL set overrun; overrun SHALL clear only on reset.
REQ-028 A start in the same cycle as the final mag_valid SHALL count as LOAD (ignored, sets overrun).
REQ-029 rd_data SHALL be registered with 1-cycle latency; a read issued in the swap cycle SHALL return the old front bank.
REQ-030 Gaps between mag_valid pulses SHALL be unbounded; no timeout.
REQ-031 busy SHALL equal (state == LOAD).

Reset
REQ-032 reset SHALL force: IDLE, cnt = 0, bank select = 0, frame counter = 0, mode_q = live, busy = 0, frame_done = 0, overrun = 0, rd_data = 0.
REQ-033 reset SHALL clear every entry of both banks to 0.
REQ-034 reset during LOAD SHALL abort the frame with no swap and no frame_done.
REQ-035 reset SHALL take priority over start and mag_valid in the same cycle.

Verification (N_BINS = 8, SHIFT = 2, OUT_WIDTH = 9, DECAY_DIV = 2, DECAY_STEP = 1)
REQ-036 Live frame: start, mode = 00, 8 mag_valid with mag_data = 4*k (k = 0..7) -> frame_done pulse 1 cycle after the 8th; rd_addr = k returns k after 1 cycle; busy low.
REQ-037 Saturation: mag_data = 32'h0000_1000 in bin 3 -> rd_data[3] = 511; mag_data = 2044 -> 511; mag_data = 2048 -> 511 (no wrap).
REQ-038 Peak-hold:
- Frame A has bin 2 = 400 (scaled 100); frame B has bin 2 = 40 (scaled 10), mode 01 -> bin 2 reads 100.
- Frame C has bin 2 = 800, mode 01 -> bin 2 reads 200.
REQ-039 Peak-decay: held value 5 in bin 0, input 0, mode 10 -> bin 0 reads 5, 4, 4, 3 over frames 1-4 (decay on odd frame index); held value 0 stays 0.
REQ-040 Overrun and abort:
- start pulsed at bin 4 of LOAD -> overrun = 1 and the frame completes normally.
- reset at bin 5 of the next frame -> all outputs 0, no frame_done, rd_data 0 at every address.
REQ-041 Swap boundary: rd_addr held at 1 across the final mag_valid -> rd_data shows the old value in the cycle after the swap edge and the new value one cycle later.
